// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared game state type and die face constants
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SCORE,
      WIN
   } game_state_t;

   localparam logic [2:0] DIE_MIN  = 3'd1;
   localparam logic [2:0] DIE_MAX  = 3'd6;
   localparam logic [2:0] PIG_FACE = 3'd1;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - W-bit unsigned adder clamping at the all-ones value
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   logic [W:0] sum;

   // carry out of the top bit means the true sum does not fit, so clamp
   assign sum = {1'b0, a} + {1'b0, b};
   assign y   = sum[W] ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/pig_game.sv
// rtl/pig_game.sv - two-player Pig controller driving the die roller
module pig_game #(
   parameter int TARGET  = 100,
   parameter int SCORE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         roll_num,
   input  logic               roll_choose,
   input  logic               hold,
   output logic               roll_enable,
   output logic               player,
   output logic [SCORE_W-1:0] turn_total,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic [2:0]         last_roll,
   output logic               winner_valid,
   output logic               winner
);

   import dice_pkg::*;

   localparam logic [SCORE_W-1:0] TARGET_V = SCORE_W'(TARGET);

   game_state_t        state;
   game_state_t        state_nxt;
   logic               hold_q;
   logic               capture;
   logic               bank;
   logic               win_bank;
   logic [SCORE_W-1:0] roll_ext;
   logic [SCORE_W-1:0] cur_score;
   logic [SCORE_W-1:0] turn_sum;
   logic [SCORE_W-1:0] bank_score;

   // a settled, legal face is captured; a hold edge only counts with the roller idle
   assign capture  = (state == ARMED) && roll_choose &&
                     (roll_num >= DIE_MIN) && (roll_num <= DIE_MAX);
   assign bank     = (state == ARMED) && hold && !hold_q &&
                     (roll_num == 3'd0) && !roll_choose;
   assign win_bank = bank && (bank_score >= TARGET_V);

   assign roll_ext    = {{(SCORE_W-3){1'b0}}, last_roll};
   assign cur_score   = player ? score1 : score0;
   assign roll_enable = (state == ARMED);

   sat_add #(.W(SCORE_W)) u_turn_add (
      .a (turn_total),
      .b (roll_ext),
      .y (turn_sum)
   );

   sat_add #(.W(SCORE_W)) u_bank_add (
      .a (cur_score),
      .b (turn_total),
      .y (bank_score)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode; capture takes priority over a same-cycle hold edge
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = ARMED;
         ARMED: begin
            if (capture) begin
               state_nxt = SCORE;
            end else if (win_bank) begin
               state_nxt = WIN;
            end
         end
         SCORE:   state_nxt = ARMED;
         WIN:     state_nxt = WIN;
         default: state_nxt = IDLE;
      endcase
   end

   // hold history is tracked in every state so no stale edge survives WIN or reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= 1'b0;
      end else begin
         hold_q <= hold;
      end
   end

   // roll capture, turn accumulation, banking and winner latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         player       <= 1'b0;
         turn_total   <= '0;
         score0       <= '0;
         score1       <= '0;
         last_roll    <= 3'd0;
         winner_valid <= 1'b0;
         winner       <= 1'b0;
      end else begin
         if (capture) begin
            last_roll <= roll_num;
         end
         if (state == SCORE) begin
            if (last_roll == PIG_FACE) begin
               turn_total <= '0;
               player     <= ~player;
            end else begin
               turn_total <= turn_sum;
            end
         end
         if (bank) begin
            if (player) begin
               score1 <= bank_score;
            end else begin
               score0 <= bank_score;
            end
            turn_total <= '0;
            if (win_bank) begin
               winner_valid <= 1'b1;
               winner       <= player;
            end else begin
               player <= ~player;
            end
         end
      end
   end

endmodule

// File: tb/tb_pig_game.sv
// tb/tb_pig_game.sv - directed table-driven bench for pig_game
module tb_pig_game;

   typedef struct {
      bit is_hold;
      int val;
      int turn;
      int plyr;
      int s0;
      int s1;
      int wv;
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [2:0] roll_num = 3'd0;
   logic       roll_choose = 1'b0;
   logic       hold = 1'b0;
   logic       roll_enable, player, winner_valid, winner;
   logic [7:0] turn_total, score0, score1;
   logic [2:0] last_roll;

   logic [2:0] roll_num2 = 3'd0;
   logic       roll_choose2 = 1'b0;
   logic       hold2 = 1'b0;
   logic       roll_enable2, player2, winner_valid2, winner2;
   logic [3:0] turn_total2, score0_2, score1_2;
   logic [2:0] last_roll2;

   int total = 0;
   int bad = 0;

   step_t tbl_a[$];
   step_t tbl_b[$];

   always #5 clk = ~clk;

   pig_game #(.TARGET(100), .SCORE_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .roll_num     (roll_num),
      .roll_choose  (roll_choose),
      .hold         (hold),
      .roll_enable  (roll_enable),
      .player       (player),
      .turn_total   (turn_total),
      .score0       (score0),
      .score1       (score1),
      .last_roll    (last_roll),
      .winner_valid (winner_valid),
      .winner       (winner)
   );

   pig_game #(.TARGET(15), .SCORE_W(4)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .roll_num     (roll_num2),
      .roll_choose  (roll_choose2),
      .hold         (hold2),
      .roll_enable  (roll_enable2),
      .player       (player2),
      .turn_total   (turn_total2),
      .score0       (score0_2),
      .score1       (score1_2),
      .last_roll    (last_roll2),
      .winner_valid (winner_valid2),
      .winner       (winner2)
   );

   function automatic step_t mk(bit h, int v, int t, int p, int a, int b, int w);
      step_t s;
      s.is_hold = h;
      s.val     = v;
      s.turn    = t;
      s.plyr    = p;
      s.s0      = a;
      s.s1      = b;
      s.wv      = w;
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int t, input int p,
                              input int a, input int b, input int w);
      chk({tag, " turn"}, int'(turn_total), t);
      chk({tag, " player"}, int'(player), p);
      chk({tag, " score0"}, int'(score0), a);
      chk({tag, " score1"}, int'(score1), b);
      chk({tag, " win_valid"}, int'(winner_valid), w);
   endtask

   // one roll: choose pulse for a cycle, then roller reads 0 while SCORE runs
   task automatic do_roll(input bit which, input int v);
      if (which) begin
         roll_num2 = 3'(v);
         roll_choose2 = 1'b1;
      end else begin
         roll_num = 3'(v);
         roll_choose = 1'b1;
      end
      tick();
      chk($sformatf("cap_last%0d", v), which ? int'(last_roll2) : int'(last_roll), v);
      chk("cap_en_low", which ? int'(roll_enable2) : int'(roll_enable), 0);
      roll_num = 3'd0;
      roll_choose = 1'b0;
      roll_num2 = 3'd0;
      roll_choose2 = 1'b0;
      tick();
   endtask

   task automatic apply_step(input string tag, input step_t s);
      if (!s.is_hold) begin
         do_roll(1'b0, s.val);
         chk({tag, " en_back"}, int'(roll_enable), 1);
         check_state(tag, s.turn, s.plyr, s.s0, s.s1, s.wv);
      end else begin
         hold = 1'b1;
         tick();
         check_state(tag, s.turn, s.plyr, s.s0, s.s1, s.wv);
         if (s.wv != 0) begin
            chk({tag, " winner"}, int'(winner), s.plyr);
         end
         repeat (4) tick();
         check_state({tag, " held"}, s.turn, s.plyr, s.s0, s.s1, s.wv);
         hold = 1'b0;
         tick();
         chk({tag, " en_after"}, int'(roll_enable), (s.wv != 0) ? 0 : 1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " roll_enable"}, int'(roll_enable), 0);
      chk({tag, " last_roll"}, int'(last_roll), 0);
      chk({tag, " winner"}, int'(winner), 0);
      check_state(tag, 0, 0, 0, 0, 0);
      chk({tag, " en4"}, int'(roll_enable2), 0);
      chk({tag, " turn4"}, int'(turn_total2), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // player 0 rolls 4,5 and banks 9; player 1 rolls 5,4 then pigs out on 1
      tbl_a.push_back(mk(0, 4, 4, 0, 0, 0, 0));
      tbl_a.push_back(mk(0, 5, 9, 0, 0, 0, 0));
      tbl_a.push_back(mk(1, 0, 0, 1, 9, 0, 0));
      tbl_a.push_back(mk(0, 5, 5, 1, 9, 0, 0));
      tbl_a.push_back(mk(0, 4, 9, 1, 9, 0, 0));
      tbl_a.push_back(mk(0, 1, 0, 0, 9, 0, 0));

      // player 0 climbs from turn 4 to 86, banks 95; player 1 passes; 6 then bank wins
      for (int i = 1; i <= 13; i++) begin
         tbl_b.push_back(mk(0, 6, 4 + 6 * i, 0, 9, 0, 0));
      end
      tbl_b.push_back(mk(0, 4, 86, 0, 9, 0, 0));
      tbl_b.push_back(mk(1, 0, 0, 1, 95, 0, 0));
      tbl_b.push_back(mk(1, 0, 0, 0, 95, 0, 0));
      tbl_b.push_back(mk(0, 6, 6, 0, 95, 0, 0));
      tbl_b.push_back(mk(1, 0, 0, 0, 101, 0, 1));

      repeat (3) tick();
      check_reset_outputs("in_reset");
      rst = 1'b0;
      chk("en_at_release", int'(roll_enable), 0);
      tick();
      chk("en_one_cycle", int'(roll_enable), 1);

      for (int i = 0; i < tbl_a.size(); i++) begin
         apply_step($sformatf("a%0d", i), tbl_a[i]);
      end

      // hold raised mid-roll is dropped, and not replayed once the roller clears
      roll_num = 3'd3;
      hold = 1'b1;
      repeat (2) tick();
      check_state("midroll", 0, 0, 9, 0, 0);
      roll_num = 3'd0;
      tick();
      check_state("midroll_clr", 0, 0, 9, 0, 0);
      hold = 1'b0;
      tick();

      // hold edge coincident with capture: the roll is scored, no bank
      roll_num = 3'd4;
      roll_choose = 1'b1;
      hold = 1'b1;
      tick();
      chk("simul last", int'(last_roll), 4);
      chk("simul en", int'(roll_enable), 0);
      roll_num = 3'd0;
      roll_choose = 1'b0;
      tick();
      check_state("simul", 4, 0, 9, 0, 0);
      hold = 1'b0;
      tick();

      for (int i = 0; i < tbl_b.size(); i++) begin
         apply_step($sformatf("b%0d", i), tbl_b[i]);
      end

      // WIN is terminal: choose and hold activity must change nothing
      roll_num = 3'd5;
      roll_choose = 1'b1;
      tick();
      roll_num = 3'd0;
      roll_choose = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hold = ~hold;
         tick();
      end
      check_state("win_frozen", 0, 0, 101, 0, 1);
      chk("win_frozen last", int'(last_roll), 6);
      chk("win_frozen winner", int'(winner), 0);
      chk("win_frozen en", int'(roll_enable), 0);

      // reset with hold held high: immediate clear, no spurious bank afterwards
      hold = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst en", int'(roll_enable), 1);
      check_state("post_rst", 0, 0, 0, 0, 0);
      hold = 1'b0;
      tick();

      // 4-bit instance: 6+4+3 = 13, then +6 clamps at 15
      do_roll(1'b1, 6);
      chk("w4 turn6", int'(turn_total2), 6);
      do_roll(1'b1, 4);
      chk("w4 turn10", int'(turn_total2), 10);
      do_roll(1'b1, 3);
      chk("w4 turn13", int'(turn_total2), 13);
      do_roll(1'b1, 6);
      chk("w4 sat", int'(turn_total2), 15);
      chk("w4 player", int'(player2), 0);
      chk("w4 en", int'(roll_enable2), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pig_game.md
# pig_game

Two-player "Pig" dice-game controller that consumes the output of the button-driven die roller. It enables the roller, captures each settled roll on the roller's `choose` indication, and accumulates a per-turn total. A player loses the turn total on a roll of 1, or banks it with the hold button. The block declares a winner when a banked score reaches `TARGET`, and sits between the roller and the score/seven-segment display logic.

## Interface
Parameters:
- `TARGET`, 100, winning banked score (must be < 2^SCORE_W)
- `SCORE_W`, 8, width of the score and turn-total registers

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `roll_num`  in  3  current die value from the roller (0 = idle, 1..6 = valid)
- `roll_choose`  in  1  roller indication that `roll_num` is settled (button released)
- `hold`  in  1  debounced hold button, level
- `roll_enable`  out  1  enables the roller; low forces the roller back to 0
- `player`  out  1  current player, 0 or 1
- `turn_total`  out  SCORE_W  unbanked total for the current turn
- `score0`, `score1`  out  SCORE_W  banked scores
- `last_roll`  out  3  most recently captured roll
- `winner_valid`  out  1  game over
- `winner`  out  1  winning player; valid only when `winner_valid` is high

## Operation
- States: IDLE, ARMED, SCORE, WIN.
- `roll_enable` = (state == ARMED), decoded from the state register.
- IDLE: exits to ARMED unconditionally after one cycle.
- ARMED, capture: `roll_choose` = 1 and `roll_num` in 1..6 latches `roll_num` into `last_roll` and moves to SCORE.
  - If `roll_choose` = 1 with `roll_num` of 0 or 7, the value is ignored and the state stays ARMED.
- ARMED, bank: taken on a rising edge of `hold` (`hold` & !`hold_q`) when `roll_num` == 0 and `roll_choose` == 0.
  - The current player's score becomes sat(score + `turn_total`) and `turn_total` becomes 0.
  - If the new score ≥ `TARGET`: go to WIN, `winner` = `player`, `winner_valid` = 1.
  - Otherwise toggle `player` and stay in ARMED.
  - A hold edge while a roll is in progress (`roll_num` != 0) is dropped, not deferred.
  - Banking with `turn_total` = 0 is legal and simply passes the turn.
- SCORE, one cycle, `roll_enable` = 0 so the roller clears:
  - `last_roll` == 1: `turn_total` becomes 0 and `player` toggles.
  - Otherwise `turn_total` becomes sat(`turn_total` + `last_roll`).
  - Always returns to ARMED.
- WIN: terminal. `roll_enable` = 0, all scores frozen, `roll_choose` and `hold` ignored. Only `rst` leaves WIN.
- Simultaneous capture condition and hold edge in ARMED: the roll capture wins and the hold edge is dropped.
- Arithmetic: all additions saturate at 2^SCORE_W−1. `last_roll` is zero-extended before adding.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `hold_q` = 0, and all outputs = 0, including `roll_enable`, `player`, the scores, `turn_total`, `last_roll`, `winner_valid` and `winner`.
- Reset asserted mid-SCORE or mid-WIN aborts the game entirely; there is no partial update.
- `roll_enable` rises 1 cycle after reset deassertion.
- Capture at edge k makes `last_roll` valid after edge k. `turn_total`/`player` update at edge k+1, and ARMED resumes at k+1.
- During the SCORE cycle `roll_enable` = 0, so the roller reads 0 from edge k+1 onward. A still-held button restarts the roller from 1.
- Bank: the score, `player` and `winner_valid` update at the same edge that detects the hold edge, with 1-cycle latency from the `hold` rise.
- `hold_q` registers `hold` every cycle in every state, so a hold held across WIN exit or reset never produces a spurious edge.

## Structure
- Package `dice_pkg`: state enum `game_state_t` (IDLE, ARMED, SCORE, WIN), `DIE_MIN` = 1, `DIE_MAX` = 6, `PIG_FACE` = 1.
- One sub-module, `sat_add #(W)`: a W-bit plus W-bit saturating adder, instanced for both the turn-total and bank paths.

## Test plan
- Reset, then release: all outputs 0 during reset; `roll_enable` = 1 exactly one cycle after `rst` falls.
- Player 0 rolls 4, then 5, each with `roll_choose` pulsed: `last_roll` = 4 then 5, `turn_total` = 4 then 9, `player` stays 0, and `roll_enable` is low for one cycle after each capture.
- With `turn_total` = 9, roll 1: `turn_total` = 0, `player` = 1, `score0`/`score1` unchanged.
- With `turn_total` = 9, raise `hold` and keep it high for 5 cycles: `score0` = 9 exactly once, `player` = 1, `turn_total` = 0. Raising `hold` while `roll_num` = 3 mid-roll changes nothing.
- With `score0` = 95 and `turn_total` = 6, hold: `score0` = 101, `winner_valid` = 1, `winner` = 0, `roll_enable` = 0. Further `choose`/`hold` activity changes nothing until `rst`.
- `hold` rises in the same cycle a capture occurs: the roll is scored and no bank happens. Separately, `SCORE_W` = 4 with `turn_total` = 13 plus a roll of 6 gives `turn_total` = 15 (saturated).
